n101_tlwidthwidget_up8to32: RTL

- TileLink-UL width widget that upsizes an 8-bit master port to a 32-bit slave port. It is the mirror of the 32-to-8 narrowing widget in front of the QSPI.
- A channel: PutFull/PutPartial bursts of 2^size byte beats are packed into one 32-bit beat. A Get is forwarded as one 32-bit beat.
- D channel: a 32-bit AccessAckData is split into 2^size byte beats. An AccessAck passes through as one beat.
- Sits between byte-wide initiators (debug/DMA bridge) and the 32-bit peripheral crossbar.

---
 rtl/n101_tlwidthwidget_up8to32.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/n101_tlwidthwidget_up8to32.sv
// TileLink-UL width widget: packs 8-bit A bursts into 32-bit beats and splits 32-bit D beats into bytes.
// Optional size checking enabled by defining N101_TLWW_UP8TO32_SIZE_CHECK_EN.
module n101_tlwidthwidget_up8to32 #(
   parameter int ADDR_W = 30,
   parameter int SRC_W  = 2
) (
   input  logic              clock,
   input  logic              reset,
   output logic              io_in_a_ready,
   input  logic              io_in_a_valid,
   input  logic [2:0]        io_in_a_bits_opcode,
   input  logic [2:0]        io_in_a_bits_param,
   input  logic [2:0]        io_in_a_bits_size,
   input  logic [SRC_W-1:0]  io_in_a_bits_source,
   input  logic [ADDR_W-1:0] io_in_a_bits_address,
   input  logic              io_in_a_bits_mask,
   input  logic [7:0]        io_in_a_bits_data,
   input  logic              io_in_d_ready,
   output logic              io_in_d_valid,
   output logic [2:0]        io_in_d_bits_opcode,
   output logic [1:0]        io_in_d_bits_param,
   output logic [2:0]        io_in_d_bits_size,
   output logic [SRC_W-1:0]  io_in_d_bits_source,
   output logic              io_in_d_bits_sink,
   output logic [1:0]        io_in_d_bits_addr_lo,
   output logic [7:0]        io_in_d_bits_data,
   output logic              io_in_d_bits_error,
   input  logic              io_out_a_ready,
   output logic              io_out_a_valid,
   output logic [2:0]        io_out_a_bits_opcode,
   output logic [2:0]        io_out_a_bits_param,
   output logic [2:0]        io_out_a_bits_size,
   output logic [SRC_W-1:0]  io_out_a_bits_source,
   output logic [ADDR_W-1:0] io_out_a_bits_address,
   output logic [3:0]        io_out_a_bits_mask,
   output logic [31:0]       io_out_a_bits_data,
   output logic              io_out_d_ready,
   input  logic              io_out_d_valid,
   input  logic [2:0]        io_out_d_bits_opcode,
   input  logic [1:0]        io_out_d_bits_param,
   input  logic [2:0]        io_out_d_bits_size,
   input  logic [SRC_W-1:0]  io_out_d_bits_source,
   input  logic              io_out_d_bits_sink,
   input  logic [1:0]        io_out_d_bits_addr_lo,
   input  logic [31:0]       io_out_d_bits_data,
   input  logic              io_out_d_bits_error,
   output logic              io_size_err
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_HOLD    = 2'd2;

   localparam logic [2:0] OPC_PUT_FULL = 3'd0;
   localparam logic [2:0] OPC_PUT_PART = 3'd1;
   localparam logic [2:0] OPC_GET      = 3'd4;
   localparam logic [2:0] OPC_ACK_DATA = 3'd1;

   function automatic logic [1:0] clamp_size(input logic [2:0] s);
      return (s > 3'd2) ? 2'd2 : s[1:0];
   endfunction

   function automatic logic [1:0] last_idx(input logic [1:0] s);
      case (s)
         2'd0:    return 2'd0;
         2'd1:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   // Contiguous lane mask of 2^s lanes rotated to start at the given lane.
   function automatic logic [3:0] get_mask(input logic [1:0] s, input logic [1:0] lane);
      logic [3:0] base;
      logic [7:0] dbl;
      case (s)
         2'd0:    base = 4'b0001;
         2'd1:    base = 4'b0011;
         default: base = 4'b1111;
      endcase
      dbl = {base, base} << lane;
      return dbl[7:4];
   endfunction

   logic [1:0]        st_q, st_d;
   logic [1:0]        a_cnt_q, a_cnt_d;
   logic [1:0]        d_cnt_q, d_cnt_d;
   logic [2:0]        opcode_q, opcode_d;
   logic [2:0]        param_q, param_d;
   logic [1:0]        size_q, size_d;
   logic [SRC_W-1:0]  source_q, source_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        mask_q, mask_d;
   logic [31:0]       data_q, data_d;

   logic       a_fire, first_beat;
   logic [1:0] lane, sz;
   logic [1:0] d_lane, d_last_idx;
   logic       d_last;

   assign io_in_a_ready = (st_q != ST_HOLD) | io_out_a_ready;
   assign a_fire        = io_in_a_valid & io_in_a_ready;
   assign first_beat    = (st_q != ST_COLLECT);

   always_comb begin
      st_d     = st_q;
      a_cnt_d  = a_cnt_q;
      opcode_d = opcode_q;
      param_d  = param_q;
      size_d   = size_q;
      source_d = source_q;
      addr_d   = addr_q;
      mask_d   = mask_q;
      data_d   = data_q;
      lane     = 2'd0;
      sz       = 2'd0;
      if (st_q == ST_HOLD && io_out_a_ready) st_d = ST_IDLE;
      if (a_fire) begin
         if (first_beat) begin
            sz       = clamp_size(io_in_a_bits_size);
            lane     = io_in_a_bits_address[1:0];
            opcode_d = io_in_a_bits_opcode;
            param_d  = io_in_a_bits_param;
            size_d   = sz;
            source_d = io_in_a_bits_source;
            addr_d   = io_in_a_bits_address;
            a_cnt_d  = 2'd0;
            if (io_in_a_bits_opcode == OPC_PUT_FULL || io_in_a_bits_opcode == OPC_PUT_PART) begin
               mask_d                     = 4'd0;
               mask_d[lane]               = io_in_a_bits_mask;
               data_d[{lane, 3'b000} +: 8] = io_in_a_bits_data;
               if (last_idx(sz) == 2'd0) begin
                  st_d = ST_HOLD;
               end else begin
                  st_d    = ST_COLLECT;
                  a_cnt_d = 2'd1;
               end
            end else if (io_in_a_bits_opcode == OPC_GET) begin
               mask_d = get_mask(sz, lane);
               data_d = 32'd0;
               st_d   = ST_HOLD;
            end else begin
               mask_d = 4'(io_in_a_bits_mask) << lane;
               data_d = 32'(io_in_a_bits_data) << {lane, 3'b000};
               st_d   = ST_HOLD;
            end
         end else begin
            lane                        = addr_q[1:0] + a_cnt_q;
            mask_d[lane]                = io_in_a_bits_mask;
            data_d[{lane, 3'b000} +: 8] = io_in_a_bits_data;
            if (a_cnt_q == last_idx(size_q)) begin
               st_d    = ST_HOLD;
               a_cnt_d = 2'd0;
            end else begin
               a_cnt_d = a_cnt_q + 2'd1;
            end
         end
      end
   end

   // D path: pure lane selection, only the beat counter is stateful.
   assign d_lane     = io_out_d_bits_addr_lo + d_cnt_q;
   assign d_last_idx = (io_out_d_bits_opcode == OPC_ACK_DATA) ? last_idx(clamp_size(io_out_d_bits_size)) : 2'd0;
   assign d_last     = (d_cnt_q == d_last_idx);

   always_comb begin
      d_cnt_d = d_cnt_q;
      if (io_out_d_valid && io_in_d_ready) d_cnt_d = d_last ? 2'd0 : d_cnt_q + 2'd1;
   end

   assign io_in_d_valid        = io_out_d_valid;
   assign io_in_d_bits_opcode  = io_out_d_bits_opcode;
   assign io_in_d_bits_param   = io_out_d_bits_param;
   assign io_in_d_bits_size    = io_out_d_bits_size;
   assign io_in_d_bits_source  = io_out_d_bits_source;
   assign io_in_d_bits_sink    = io_out_d_bits_sink;
   assign io_in_d_bits_error   = io_out_d_bits_error;
   assign io_in_d_bits_addr_lo = d_lane;
   assign io_in_d_bits_data    = io_out_d_bits_data[{d_lane, 3'b000} +: 8];
   assign io_out_d_ready       = io_in_d_ready & d_last;

   assign io_out_a_valid        = (st_q == ST_HOLD);
   assign io_out_a_bits_opcode  = opcode_q;
   assign io_out_a_bits_param   = param_q;
   assign io_out_a_bits_size    = {1'b0, size_q};
   assign io_out_a_bits_source  = source_q;
   assign io_out_a_bits_address = addr_q;
   assign io_out_a_bits_mask    = mask_q;
   assign io_out_a_bits_data    = data_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         st_q    <= ST_IDLE;
         a_cnt_q <= 2'd0;
         d_cnt_q <= 2'd0;
      end else begin
         st_q    <= st_d;
         a_cnt_q <= a_cnt_d;
         d_cnt_q <= d_cnt_d;
      end
   end

   // Holding register contents are qualified by st_q, so they need no reset.
   always_ff @(posedge clock) begin
      opcode_q <= opcode_d;
      param_q  <= param_d;
      size_q   <= size_d;
      source_q <= source_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      data_q   <= data_d;
   end

`ifdef N101_TLWW_UP8TO32_SIZE_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (a_fire && first_beat && io_in_a_bits_size > 3'd2) err_d = 1'b1;
      if (io_out_d_valid && io_in_d_ready && io_out_d_bits_size > 3'd2) err_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign io_size_err = err_q;
`else
   assign io_size_err = 1'b0;
`endif

endmodule
